// File: rtl/operand_seq_loader_if.sv
// Operand loader bus: keypad/switch inputs, compute handshake
// and captured-operand status outputs.
interface operand_seq_loader_if #(
  parameter int WIDTH   = 16,
  parameter int NUM_OPS = 4
);
  logic [WIDTH-1:0]         data_in;
  logic                     enter;
  logic                     abort;
  logic                     done;
  logic [NUM_OPS*WIDTH-1:0] ops;
  logic                     start;
  logic [2:0]               op_idx;
  logic [NUM_OPS-1:0]       loaded;
  logic                     busy;
  logic                     complete;
  logic                     error;

  modport master (
    output data_in, enter, abort, done,
    input  ops, start, op_idx, loaded,
    input  busy, complete, error
  );

  modport slave (
    input  data_in, enter, abort, done,
    output ops, start, op_idx, loaded,
    output busy, complete, error
  );
endinterface

// File: rtl/operand_seq_loader.sv
// Sequential operand loader: captures NUM_OPS keyed values,
// then starts the compute unit and waits for done or timeout.
module operand_seq_loader #(
  parameter int WIDTH   = 16,
  parameter int NUM_OPS = 4,
  parameter int TIMEOUT = 1000
) (
  input logic                clk,
  input logic                rst,
  operand_seq_loader_if.slave bus
);

  typedef enum logic [2:0] {
    WAIT     = 3'd0,
    CAPTURE  = 3'd1,
    HOLD     = 3'd2,
    START    = 3'd3,
    RUN      = 3'd4,
    COMPLETE = 3'd5,
    ERROR    = 3'd6
  } state_t;

  localparam logic [19:0] CNT_LAST = 20'(TIMEOUT - 1);
  localparam logic [2:0]  IDX_LAST = 3'(NUM_OPS - 1);

  state_t                   state_q, state_d;
  logic [NUM_OPS*WIDTH-1:0] ops_q, ops_d;
  logic [2:0]               idx_q, idx_d;
  logic [NUM_OPS-1:0]       loaded_q, loaded_d;
  logic [19:0]              cnt_q, cnt_d;
  logic                     start_q;
  logic                     busy_q;
  logic                     complete_q;
  logic                     error_q;

  always_comb begin
    state_d  = state_q;
    ops_d    = ops_q;
    idx_d    = idx_q;
    loaded_d = loaded_q;
    cnt_d    = cnt_q;
    // abort outranks every other event in the same cycle
    if (bus.abort) begin
      state_d  = WAIT;
      idx_d    = 3'd0;
      loaded_d = '0;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        WAIT: begin
          if (!bus.enter) state_d = CAPTURE;
        end
        CAPTURE: begin
          for (int k = 0; k < NUM_OPS; k++) begin
            if (idx_q == 3'(k)) begin
              ops_d[k*WIDTH +: WIDTH] = bus.data_in;
              loaded_d[k]             = 1'b1;
            end
          end
          state_d = HOLD;
        end
        HOLD: begin
          if (bus.enter) begin
            if (idx_q == IDX_LAST) begin
              state_d = START;
            end else begin
              idx_d   = idx_q + 3'd1;
              state_d = WAIT;
            end
          end
        end
        START: begin
          cnt_d   = '0;
          state_d = RUN;
        end
        RUN: begin
          cnt_d = cnt_q + 20'd1;
          if (bus.done) begin
            state_d = COMPLETE;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ERROR;
          end
        end
        COMPLETE: begin
          if (!bus.enter) begin
            idx_d    = 3'd0;
            loaded_d = '0;
            state_d  = CAPTURE;
          end
        end
        ERROR: begin
          state_d = ERROR;
        end
        default: begin
          state_d = WAIT;
        end
      endcase
    end
  end

  // status flags are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= WAIT;
      ops_q      <= '0;
      idx_q      <= 3'd0;
      loaded_q   <= '0;
      cnt_q      <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ops_q      <= ops_d;
      idx_q      <= idx_d;
      loaded_q   <= loaded_d;
      cnt_q      <= cnt_d;
      start_q    <= (state_d == START);
      busy_q     <= (state_d == START) || (state_d == RUN);
      complete_q <= (state_d == COMPLETE);
      error_q    <= (state_d == ERROR);
    end
  end

  assign bus.ops      = ops_q;
  assign bus.op_idx   = idx_q;
  assign bus.loaded   = loaded_q;
  assign bus.start    = start_q;
  assign bus.busy     = busy_q;
  assign bus.complete = complete_q;
  assign bus.error    = error_q;

endmodule

// File: tb/tb_operand_seq_loader.sv
// Directed scoreboard bench for operand_seq_loader:
// load, handshake, timeout, abort, reset and restart.
module tb_operand_seq_loader;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  operand_seq_loader_if #(.WIDTH(W), .NUM_OPS(N)) bus ();

  operand_seq_loader #(
    .WIDTH(W),
    .NUM_OPS(N),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          total  = 0;
  int          passed = 0;
  string       tag_q[$];
  logic [63:0] exp_q[$];
  logic [15:0] m_ops[N];
  logic [3:0]  m_ld;

  task automatic push(input string t, input logic [63:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input logic [63:0] obs);
    string       t;
    logic [63:0] e;
    t = "scoreboard_underflow";
    e = 'x;
    if (exp_q.size() > 0) begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
    end
    total++;
    assert (obs === e) passed++;
    else $error("FAIL %s observed=%h expected=%h", t, obs, e);
  endtask

  function automatic logic [63:0] st(
    input logic s, input logic b, input logic c, input logic e,
    input logic [2:0] i, input logic [3:0] l
  );
    return 64'({s, b, c, e, i, l});
  endfunction

  function automatic logic [63:0] status();
    return 64'({bus.start, bus.busy, bus.complete,
                bus.error, bus.op_idx, bus.loaded});
  endfunction

  function automatic logic [63:0] m_pack();
    return {m_ops[3], m_ops[2], m_ops[1], m_ops[0]};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // press/release all operands; ends one cycle into RUN
  task automatic load_all(input logic [63:0] vals);
    for (int i = 0; i < N; i++) begin
      bus.data_in = vals[i*16 +: 16];
      bus.enter   = 1'b0;
      step(1);
      push("capture_state", st(0, 0, 0, 0, 3'(i), m_ld));
      pop_check(status());
      step(1);
      m_ops[i] = vals[i*16 +: 16];
      m_ld[i]  = 1'b1;
      push("captured_ops", m_pack());
      pop_check(bus.ops);
      push("captured_flags", st(0, 0, 0, 0, 3'(i), m_ld));
      pop_check(status());
      bus.enter = 1'b1;
      step(1);
      if (i < N - 1) begin
        push("next_idx", st(0, 0, 0, 0, 3'(i + 1), m_ld));
        pop_check(status());
      end
    end
    push("start_pulse", st(1, 1, 0, 0, 3'd3, 4'hF));
    pop_check(status());
    step(1);
    push("run_entry", st(0, 1, 0, 0, 3'd3, 4'hF));
    pop_check(status());
  endtask

  task automatic key(input logic [15:0] v, input int idx);
    bus.data_in = v;
    bus.enter   = 1'b0;
    step(2);
    m_ops[idx] = v;
    m_ld[idx]  = 1'b1;
  endtask

  initial begin
    bus.data_in = '0;
    bus.enter   = 1'b1;
    bus.abort   = 1'b0;
    bus.done    = 1'b0;
    for (int i = 0; i < N; i++) m_ops[i] = '0;
    m_ld = '0;

    #3;
    push("reset_status", 64'd0);
    pop_check(status());
    push("reset_ops", 64'd0);
    pop_check(bus.ops);
    #4 rst = 1'b1;
    step(2);
    push("idle_wait", 64'd0);
    pop_check(status());

    // load and handshake
    load_all(64'hFFFF_1234_00FF_0001);
    push("load_ops", 64'hFFFF_1234_00FF_0001);
    pop_check(bus.ops);
    step(4);
    push("run_before_done", st(0, 1, 0, 0, 3'd3, 4'hF));
    pop_check(status());
    bus.done = 1'b1;
    step(1);
    push("complete", st(0, 0, 1, 0, 3'd3, 4'hF));
    pop_check(status());
    step(2);
    push("done_held", st(0, 0, 1, 0, 3'd3, 4'hF));
    pop_check(status());
    bus.done = 1'b0;

    // restart from COMPLETE
    bus.data_in = 16'hABCD;
    bus.enter   = 1'b0;
    step(1);
    m_ld = '0;
    push("restart_capture", st(0, 0, 0, 0, 3'd0, m_ld));
    pop_check(status());
    step(1);
    m_ops[0] = 16'hABCD;
    m_ld[0]  = 1'b1;
    push("restart_ops", m_pack());
    pop_check(bus.ops);
    push("restart_loaded", st(0, 0, 0, 0, 3'd0, 4'b0001));
    pop_check(status());
    bus.enter = 1'b1;
    step(1);
    push("restart_next", st(0, 0, 0, 0, 3'd1, 4'b0001));
    pop_check(status());

    // abort together with a press in WAIT
    bus.abort = 1'b1;
    bus.enter = 1'b0;
    step(1);
    m_ld = '0;
    push("abort_enter", 64'd0);
    pop_check(status());
    push("abort_ops_kept", m_pack());
    pop_check(bus.ops);
    bus.abort = 1'b0;
    bus.enter = 1'b1;
    step(1);
    push("abort_idle", 64'd0);
    pop_check(status());

    // abort while in CAPTURE drops the value
    bus.data_in = 16'h5555;
    bus.enter   = 1'b0;
    step(1);
    bus.abort = 1'b1;
    step(1);
    push("abort_capture", 64'd0);
    pop_check(status());
    push("abort_capture_ops", m_pack());
    pop_check(bus.ops);
    bus.abort = 1'b0;
    bus.enter = 1'b1;
    step(1);

    // timeout
    load_all(64'h0008_0007_0006_0005);
    step(7);
    push("last_run_cycle", st(0, 1, 0, 0, 3'd3, 4'hF));
    pop_check(status());
    step(1);
    push("timeout_error", st(0, 0, 0, 1, 3'd3, 4'hF));
    pop_check(status());
    bus.enter = 1'b0;
    step(3);
    push("error_sticky", st(0, 0, 0, 1, 3'd3, 4'hF));
    pop_check(status());
    bus.enter = 1'b1;
    bus.abort = 1'b1;
    step(1);
    m_ld = '0;
    push("error_abort", 64'd0);
    pop_check(status());
    bus.abort = 1'b0;
    step(1);

    // done on the timeout cycle wins
    load_all(64'h000C_000B_000A_0009);
    step(7);
    bus.done = 1'b1;
    step(1);
    push("done_vs_timeout", st(0, 0, 1, 0, 3'd3, 4'hF));
    pop_check(status());
    bus.done = 1'b0;

    // reset while holding operand 2
    bus.abort = 1'b1;
    step(1);
    m_ld      = '0;
    bus.abort = 1'b0;
    key(16'h1111, 0);
    bus.enter = 1'b1;
    step(1);
    key(16'h2222, 1);
    bus.enter = 1'b1;
    step(1);
    key(16'h3333, 2);
    push("hold_op2", st(0, 0, 0, 0, 3'd2, 4'b0111));
    pop_check(status());
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < N; i++) m_ops[i] = '0;
    m_ld = '0;
    push("async_reset_status", 64'd0);
    pop_check(status());
    push("async_reset_ops", m_pack());
    pop_check(bus.ops);
    #1;
    bus.enter = 1'b1;
    rst       = 1'b1;
    step(1);
    bus.data_in = 16'h4242;
    bus.enter   = 1'b0;
    step(1);
    push("post_reset_idx", st(0, 0, 0, 0, 3'd0, 4'b0000));
    pop_check(status());
    step(1);
    m_ops[0] = 16'h4242;
    m_ld[0]  = 1'b1;
    push("post_reset_ops", m_pack());
    pop_check(bus.ops);
    push("post_reset_loaded", st(0, 0, 0, 0, 3'd0, 4'b0001));
    pop_check(status());
    bus.enter = 1'b1;
    step(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/operand_seq_loader.md
OPERAND_SEQ_LOADER -- requirements
Module: operand_seq_loader

Parameters
REQ-001 WIDTH, 16, bit width of each operand; legal range 4..32.
REQ-002 NUM_OPS, 4, number of operands captured per run; legal range 2..8.
REQ-003 TIMEOUT, 1000, maximum cycles spent in RUN waiting for done; legal range 2..2^20-1.

Interface
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 data_in  in  WIDTH  debounced switch value to capture.
REQ-007 enter  in  1  debounced key, active-low; 0 means pressed.
REQ-008 abort  in  1  synchronous, active-high; returns the block to operand 0.
REQ-009 done  in  1  completion flag from the compute unit.
REQ-010 ops  out  NUM_OPS*WIDTH  captured operands; operand k occupies bits [k*WIDTH +: WIDTH].
REQ-011 start  out  1  registered pulse to the compute unit.
REQ-012 op_idx  out  3  index of the operand being waited on or captured.
REQ-013 loaded  out  NUM_OPS  bit k is set once operand k has been captured in the current run.
REQ-014 busy  out  1  high in START and RUN.
REQ-015 complete  out  1  high in COMPLETE.
REQ-016 error  out  1  high in ERROR.

Function
REQ-017 FSM states are WAIT, CAPTURE, HOLD, START, RUN, COMPLETE and ERROR; the state register, and every output, is registered.
REQ-018 WAIT: if enter==0, go to CAPTURE; otherwise stay.
REQ-019 CAPTURE lasts exactly 1 cycle:
- ops[op_idx] <= data_in.
- loaded[op_idx] <= 1.
- Go to HOLD.
REQ-020 HOLD: stay while enter==0. On release (enter==1):
- If op_idx==NUM_OPS-1, go to START.
- Otherwise op_idx <= op_idx+1 and go to WAIT.
REQ-021 START lasts 1 cycle; start is 1 for exactly that cycle and 0 in every other state.
REQ-022 RUN:
- The timeout counter clears on entry and increments once per cycle.
- done==1 goes to COMPLETE.
- Otherwise, counter==TIMEOUT-1 goes to ERROR.
- done is ignored in every state except RUN.
REQ-023 COMPLETE: enter==0 starts a new run in the next cycle:
- op_idx <= 0, loaded <= 0, go to CAPTURE.
- ops keeps its old values until each operand is overwritten.
REQ-024 ERROR is exited only by abort or reset.
REQ-025 abort==1 in any state, including mid-capture and RUN:
- Next state is WAIT.
- op_idx <= 0, loaded <= 0, counter <= 0.
- ops is unchanged.
REQ-026 abort has priority over enter, done and timeout when they occur in the same cycle.
REQ-027 If done==1 and counter==TIMEOUT-1 in the same RUN cycle, done wins and the next state is COMPLETE.
REQ-028 Latency:
- Press to captured value: 1 cycle after the press is seen in WAIT.
- Release of the last operand to start pulse: 1 cycle.
REQ-029 Outputs, by state:
- busy = (START or RUN).
- complete = COMPLETE.
- error = ERROR.
REQ-030 An unreachable state encoding goes to WAIT.

Reset
REQ-031 While rst==0, asynchronously and independent of clk:
- state = WAIT.
- ops, op_idx, loaded and the counter are all 0.
- start, busy, complete and error are all 0.
REQ-032 Releasing rst is synchronous; the first active edge evaluates WAIT.

Verification
REQ-033 Load: NUM_OPS=4, enter operands 0x0001, 0x00FF, 0x1234, 0xFFFF with press/release pairs.
- ops = {0xFFFF, 0x1234, 0x00FF, 0x0001}.
- loaded = 4'b1111.
- A 1-cycle start pulse occurs 1 cycle after the last release.
REQ-034 Handshake: done==1 arrives 5 cycles after start.
- complete = 1 on the next cycle; busy = 0 from that cycle.
- Holding done high afterwards has no effect.
REQ-035 Timeout: TIMEOUT=8, done never asserted.
- error = 1 exactly 8 cycles after entering RUN.
- abort returns the block to WAIT with op_idx = 0.
REQ-036 Simultaneous events:
- abort and enter==0 together in WAIT: stays in WAIT, loaded = 0.
- done on the timeout cycle: COMPLETE, error = 0.
REQ-037 Reset mid-operation: rst=0 while in HOLD of operand 2.
- All outputs are 0 immediately, without a clock edge.
- After release, the next press captures into op_idx 0.
REQ-038 Restart: a press in COMPLETE with data_in=0xABCD.
- ops[0] = 0xABCD.
- ops[1..3] keep their old values.
- loaded = 4'b0001.
